// File: rtl/trace_packet_fifo.sv
// rtl/trace_packet_fifo.sv - elastic trace packet buffer with drop counting and overflow marker insertion
module trace_packet_fifo #(
    parameter int          DEPTH_LOG2 = 9,
    parameter logic [15:0] OVF_TAG    = 16'hFFFF
) (
    input  logic                  mclk,
    input  logic                  reset,
    input  logic [31:0]           in_data,
    input  logic                  in_strobe,
    output logic [31:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   fill,
    output logic                  overflow_seen
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   ram_count;
    logic [31:0]           rd_data;
    logic                  rd_valid;
    logic [15:0]           drop_count;
    logic                  marker_pending;

    logic        full;
    logic        xfer;
    logic        out_load;
    logic        rd_en;
    logic        marker_write;
    logic        data_write;
    logic        wr_en;
    logic        drop;
    logic [15:0] drop_next;
    logic [31:0] wr_word;

    // Pipeline: RAM -> RAM read register (rd_data) -> out_data; fill spans all three.
    always_comb begin
        full         = (fill == FULL_LEVEL);
        xfer         = out_valid && out_ready;
        out_load     = rd_valid && (!out_valid || out_ready);
        rd_en        = (ram_count != '0) && (!rd_valid || out_load);
        drop_next    = (drop_count == 16'hFFFF) ? drop_count : drop_count + 16'd1;
        marker_write = marker_pending && !full;
        data_write   = in_strobe && !full && !marker_pending;
        wr_en        = marker_write || data_write;
        drop         = in_strobe && !marker_write && (full || marker_pending);
        wr_word      = in_data;
        if (marker_write) begin
            // A strobe landing on the marker cycle is folded into this marker's count.
            wr_word = {OVF_TAG, in_strobe ? drop_next : drop_count};
        end
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge mclk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_word;
        end
        if (rd_en) begin
            rd_data <= mem[rd_ptr];
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_count <= '0;
            rd_valid  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, rd_en})
                2'b10:   ram_count <= ram_count + CNT_ONE;
                2'b01:   ram_count <= ram_count - CNT_ONE;
                default: ram_count <= ram_count;
            endcase
            if (rd_en) begin
                rd_valid <= 1'b1;
            end else if (out_load) begin
                rd_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            fill      <= '0;
        end else begin
            if (out_load) begin
                out_data  <= rd_data;
                out_valid <= 1'b1;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
            case ({wr_en, xfer})
                2'b10:   fill <= fill + CNT_ONE;
                2'b01:   fill <= fill - CNT_ONE;
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            drop_count     <= '0;
            marker_pending <= 1'b0;
            overflow_seen  <= 1'b0;
        end else begin
            if (marker_write) begin
                drop_count     <= '0;
                marker_pending <= 1'b0;
            end else if (drop) begin
                drop_count     <= drop_next;
                marker_pending <= 1'b1;
            end
            if (drop) begin
                overflow_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trace_packet_fifo.sv
// tb/tb_trace_packet_fifo.sv - directed self-checking bench for trace_packet_fifo
module tb_trace_packet_fifo;

    logic        mclk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_strobe;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  fill;
    logic        overflow_seen;

    int total = 0;
    int bad   = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic        full_seen;

    trace_packet_fifo #(.DEPTH_LOG2(2), .OVF_TAG(16'hFFFF)) dut (
        .mclk          (mclk),
        .reset         (reset),
        .in_data       (in_data),
        .in_strobe     (in_strobe),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .fill          (fill),
        .overflow_seen (overflow_seen)
    );

    always #5 mclk = ~mclk;

    always @(negedge mclk) begin
        if (!reset && out_valid && out_ready) begin
            got_q.push_back(out_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_%0d", tag, i), (i < got_q.size()) ? got_q[i] : 32'hDEADBEEF, exp_q[i]);
        end
    endtask

    task automatic write_word(input logic [31:0] d);
        in_strobe = 1'b1;
        in_data   = d;
        tick();
        in_strobe = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_data   = '0;
        in_strobe = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_ovf", 32'(overflow_seen), 32'd0);
        reset = 1'b0;
        tick();

        // single word latency
        out_ready = 1'b1;
        write_word(32'h12345678);
        check("single_fill_e0", 32'(fill), 32'd1);
        check("single_valid_e0", 32'(out_valid), 32'd0);
        tick();
        check("single_valid_e1", 32'(out_valid), 32'd0);
        tick();
        check("single_valid_e2", 32'(out_valid), 32'd1);
        check("single_data_e2", out_data, 32'h12345678);
        tick();
        check("single_fill_e3", 32'(fill), 32'd0);
        check("single_valid_e3", 32'(out_valid), 32'd0);
        check("single_hold", out_data, 32'h12345678);

        // streaming with pointer wrap
        got_q.delete();
        exp_q.delete();
        full_seen = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            in_strobe = 1'b1;
            in_data   = 32'(i);
            tick();
            if (fill == 3'd4) full_seen = 1'b1;
            exp_q.push_back(32'(i));
        end
        in_strobe = 1'b0;
        repeat (6) begin
            tick();
            if (fill == 3'd4) full_seen = 1'b1;
        end
        check_stream("stream");
        check("stream_never_full", 32'(full_seen), 32'd0);
        check("stream_ovf", 32'(overflow_seen), 32'd0);

        // overflow and marker
        got_q.delete();
        exp_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) write_word(32'hA0 + 32'(i));
        repeat (3) tick();
        check("ovf_fill", 32'(fill), 32'd4);
        check("ovf_seen", 32'(overflow_seen), 32'd1);
        out_ready = 1'b1;
        repeat (10) tick();
        exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hFFFF0002};
        check_stream("ovf");

        // full with simultaneous write and read
        got_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) write_word(32'hB0 + 32'(i));
        repeat (3) tick();
        check("simul_fill_full", 32'(fill), 32'd4);
        out_ready = 1'b1;
        in_strobe = 1'b1;
        in_data   = 32'hB4;
        tick();
        check("simul_fill_after", 32'(fill), 32'd3);
        out_ready = 1'b0;
        in_strobe = 1'b0;
        tick();
        check("simul_fill_marker", 32'(fill), 32'd4);
        out_ready = 1'b1;
        repeat (10) tick();
        exp_q = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hFFFF0001};
        check_stream("simul");

        // strobe on the marker cycle
        got_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) write_word(32'hC0 + 32'(i));
        repeat (3) tick();
        write_word(32'hC4);
        out_ready = 1'b1;
        tick();
        write_word(32'hC5);
        check("mkcyc_fill", 32'(fill), 32'd3);
        write_word(32'hC6);
        repeat (10) tick();
        exp_q = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hFFFF0002, 32'hC6};
        check_stream("mkcyc");

        // drop counter saturation
        got_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) write_word(32'hD0 + 32'(i));
        in_strobe = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            in_data = 32'hE000_0000 + 32'(i);
            tick();
        end
        in_strobe = 1'b0;
        tick();
        check("sat_fill", 32'(fill), 32'd4);
        out_ready = 1'b1;
        repeat (10) tick();
        exp_q = '{32'hD0, 32'hD1, 32'hD2, 32'hD3, 32'hFFFFFFFF};
        check_stream("sat");

        // asynchronous reset with queued words
        got_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) write_word(32'hE0 + 32'(i));
        repeat (3) tick();
        check("rst2_fill_before", 32'(fill), 32'd3);
        check("rst2_valid_before", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst2_valid_now", 32'(out_valid), 32'd0);
        check("rst2_fill_now", 32'(fill), 32'd0);
        check("rst2_ovf_now", 32'(overflow_seen), 32'd0);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        check("rst2_valid_after", 32'(out_valid), 32'd0);
        check("rst2_fill_after", 32'(fill), 32'd0);
        check("rst2_no_output", 32'(got_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trace_packet_fifo.md
Name: trace_packet_fifo

Overview:
- Elastic buffer between the tracing state machine's 32-bit packet output (`packet_data` / `packet_strobe`) and the USB byte serializer.
- Absorbs RAM-burst packet bursts that exceed USB drain rate.
- Drops packets cleanly when full and counts them.
- After an overflow, inserts a single overflow-marker word into the stream so the host can resynchronise its timestamp and detect the loss.

Parameters:
- DEPTH_LOG2, 9: log2 of storage depth in 32-bit words (512 words, one block RAM).
- OVF_TAG, 16'hFFFF: upper 16 bits of the overflow-marker word.

Ports:
- mclk  input  1: system clock; all logic on posedge.
- reset  input  1: asynchronous, active-high reset.
- in_data  input  32: packet word from the tracer.
- in_strobe  input  1: single-cycle write request; in_data is valid this cycle.
- out_data  output  32: head-of-queue word; valid only while out_valid=1.
- out_valid  output  1: head word is available.
- out_ready  input  1: consumer accepts the head word this cycle.
- fill  output  DEPTH_LOG2+1: occupancy, i.e. words accepted and not yet transferred out.
- overflow_seen  output  1: sticky; set by the first dropped packet, cleared only by reset.

Behaviour:
- Reset (asynchronous, immediate):
  - fill=0, out_valid=0, out_data=0, overflow_seen=0.
  - Drop counter=0, marker-pending=0, read/write pointers=0.
  - Stored contents are discarded.
  - Reset asserted mid-burst loses all queued words; no marker is generated for them.
- Transfer: a word moves out on any posedge where out_valid=1 and out_ready=1.
  - out_data and out_valid are registered.
  - The next word is presented on the following cycle with no bubble while fill>1.
- Latency: in_strobe into an empty FIFO at edge N gives out_valid=1 after edge N+2. Fixed; no bypass path.
- Order: strict FIFO. Words emerge exactly as written, with the marker at its insertion point.
- Full: full = (fill == 2^DEPTH_LOG2), evaluated from registered fill at the start of the cycle.
  - A write while full is dropped even if a transfer-out occurs in the same cycle.
- Empty: out_valid=0. out_ready is ignored and has no side effects.
- Drop handling:
  - A dropped in_strobe sets marker-pending=1 and overflow_seen=1.
  - The drop counter increments, 16-bit, saturating at 16'hFFFF (no wrap).
- Marker insertion:
  - On the first cycle with marker-pending=1 and not full, write {OVF_TAG, drop_count'} instead of any data.
  - drop_count' is the counter plus 1 (saturating) if in_strobe is also high that cycle; that data word is dropped and counted into this marker.
  - That edge clears the counter and marker-pending.
  - While marker-pending=1, every in_strobe is dropped and counted. No data word may precede the marker.
- fill arithmetic:
  - fill' = fill + write_accepted − transfer_out.
  - Simultaneous accepted write and transfer leaves fill unchanged.
  - The marker write counts as an accepted write.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. Full and empty are derived from fill, not pointer compare.
- Storage is a synchronous-read RAM with a one-word output register. The output-register word is included in fill.
- No X propagation: out_data holds its last value when out_valid=0.

Test Plan (bench uses DEPTH_LOG2=2, depth 4, OVF_TAG=16'hFFFF):
- Single word: reset, in_strobe with in_data=32'h12345678 at edge 0, out_ready=1.
  - Required: out_valid=1 with out_data=32'h12345678 after edge 2, and fill back to 0 after the transfer edge.
- Streaming and wrap: 10 consecutive writes 1..10 with out_ready=1 throughout.
  - Required: outputs 1..10 in order, never full, overflow_seen=0.
- Overflow and marker: out_ready=0; write 32'hA0..32'hA5 (6 words).
  - Required: fill=4 and overflow_seen=1.
  - Then raise out_ready: out_data sequence is A0, A1, A2, A3, 32'hFFFF0002.
- Simultaneous full, write, read: full with out_ready=1 and in_strobe in the same cycle.
  - Required: the write is dropped and fill=3.
  - On the next non-full cycle the marker 32'hFFFF0001 is queued after the remaining words.
- Drop during marker cycle: full; drop 1 word; free one slot; assert in_strobe on the marker cycle.
  - Required: marker 32'hFFFF0002, with the strobed word absent.
  - The next strobed word is queued normally.
- Saturation and reset: hold full for 70000 strobes, then drain.
  - Required: marker 32'hFFFFFFFF.
  - Asserting reset while 3 words are queued drops out_valid and fill to 0 immediately, with no marker emitted afterward.
